time_setter: RTL and testbench

Front-panel input block for the clock. It debounces two raw push-buttons and runs a field-select state machine (hours, minutes, seconds). It edits shadow copies of the current time and issues a single-cycle load to the time counter when editing ends. It also drives a per-digit blank mask so the display driver can blink the field being edited. It sits between the board buttons and the time counter, mirroring the display path that carries the time out to the seven-segment digits.

---
 rtl/time_setter.sv | 221 ++++++++++++++++++++++
 tb/tb_time_setter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_setter.sv
// time_setter: front-panel input block for the clock.
//
// Debounces the raw mode/increment buttons, runs the field-select state
// machine (RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN), edits shadow copies
// of the time and issues a one-cycle load when editing ends. Also drives a
// per-digit blank mask so the display can blink the field being edited.
//
// Ports:
//   clk       system clock, rising edge
//   rst_neg   synchronous active-low reset
//   btn_mode  raw mode button, asynchronous, active-low
//   btn_inc   raw increment button, asynchronous, active-low
//   sec_in    current seconds (0-59)
//   min_in    current minutes (0-59)
//   hour_in   current hours (0-23)
//   set_sec   seconds value to load
//   set_min   minutes value to load
//   set_hour  hours value to load
//   load      one-cycle pulse, time counter copies set_*
//   editing   high while in any SET_* state
//   blank     digit blank mask, 1 = blank; [1:0] sec, [3:2] min, [5:4] hour

// One button: 2-flop synchronizer, debouncer and registered press pulse.
module time_setter_button #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_neg,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // Synchronizer: raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debouncer: the accepted level only moves after the synced level has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any cycle of
  // agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Press pulse: registered 1->0 transition of the debounced level.
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

module time_setter #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int BLINK_BIT       = 24
) (
  input  logic       clk,
  input  logic       rst_neg,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  output logic [5:0] set_sec,
  output logic [5:0] set_min,
  output logic [4:0] set_hour,
  output logic       load,
  output logic       editing,
  output logic [5:0] blank
);

  localparam int BLINK_W = BLINK_BIT + 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [4:0]           hour_next;
  logic [5:0]           min_next;
  logic [5:0]           sec_next;
  logic                 load_next;
  logic                 mode_press;
  logic                 inc_press;
  logic [BLINK_W-1:0]   blink_cnt;

  time_setter_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk     (clk),
    .rst_neg (rst_neg),
    .raw     (btn_mode),
    .press   (mode_press)
  );

  time_setter_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
    .clk     (clk),
    .rst_neg (rst_neg),
    .raw     (btn_inc),
    .press   (inc_press)
  );

  // Wrapping increments; anything already at or past the top of its range
  // (including out-of-range captured values) wraps to zero.
  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // Next-state and shadow-register logic. Mode has priority over inc when
  // both press pulses arrive in the same cycle.
  always_comb begin
    state_next = state;
    hour_next  = set_hour;
    min_next   = set_min;
    sec_next   = set_sec;
    load_next  = 1'b0;

    if (mode_press) begin
      case (state)
        RUN: begin
          state_next = SET_HOUR;
          hour_next  = hour_in;
          min_next   = min_in;
          sec_next   = sec_in;
        end
        SET_HOUR: state_next = SET_MIN;
        SET_MIN:  state_next = SET_SEC;
        SET_SEC: begin
          state_next = RUN;
          load_next  = 1'b1;
        end
        default:  state_next = RUN;
      endcase
    end else if (inc_press) begin
      case (state)
        SET_HOUR: hour_next = inc_hour(set_hour);
        SET_MIN:  min_next  = inc_sixty(set_min);
        SET_SEC:  sec_next  = inc_sixty(set_sec);
        default:  ;
      endcase
    end
  end

  // load is registered on the same edge that returns the state to RUN, so it
  // is high exactly during the first RUN cycle. A reset clears it, so an
  // abandoned edit never loads.
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      state    <= RUN;
      set_hour <= 5'd0;
      set_min  <= 6'd0;
      set_sec  <= 6'd0;
      load     <= 1'b0;
    end else begin
      state    <= state_next;
      set_hour <= hour_next;
      set_min  <= min_next;
      set_sec  <= sec_next;
      load     <= load_next;
    end
  end

  // Free-running blink counter; only its top bit is used.
  always_ff @(posedge clk) begin
    if (!rst_neg) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  always_comb begin
    editing = (state != RUN);
    blank   = 6'b000000;
    if (blink_cnt[BLINK_BIT]) begin
      case (state)
        SET_HOUR: blank = 6'b110000;
        SET_MIN:  blank = 6'b001100;
        SET_SEC:  blank = 6'b000011;
        default:  blank = 6'b000000;
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
module tb_time_setter;

  localparam int DB = 4;
  localparam int BB = 3;

  logic       clk = 1'b0;
  logic       rst_neg = 1'b0;
  logic       btn_mode = 1'b1;
  logic       btn_inc = 1'b1;
  logic [5:0] sec_in = 6'd0;
  logic [5:0] min_in = 6'd0;
  logic [4:0] hour_in = 5'd0;
  logic [5:0] set_sec;
  logic [5:0] set_min;
  logic [4:0] set_hour;
  logic       load;
  logic       editing;
  logic [5:0] blank;

  time_setter #(.DEBOUNCE_CYCLES(DB), .BLINK_BIT(BB)) dut (
    .clk      (clk),
    .rst_neg  (rst_neg),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_in   (sec_in),
    .min_in   (min_in),
    .hour_in  (hour_in),
    .set_sec  (set_sec),
    .set_min  (set_min),
    .set_hour (set_hour),
    .load     (load),
    .editing  (editing),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observers: load pulse count, values at load, back-to-back detection,
  // and cycles since the last reset edge (for the blink phase).
  int load_cnt = 0;
  int ld_h = 0, ld_m = 0, ld_s = 0;
  bit load_prev = 1'b0;
  bit load_consec = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    if (!rst_neg) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt <= load_cnt + 1;
      ld_h <= int'(set_hour);
      ld_m <= int'(set_min);
      ld_s <= int'(set_sec);
      if (load_prev) load_consec <= 1'b1;
    end
    load_prev <= (load === 1'b1);
  end

  // Reference model at press-event level.
  int m_st = 0;  // 0 run, 1 hour, 2 min, 3 sec
  int mh = 0, mm = 0, ms = 0;
  int exp_loads = 0;

  typedef struct {
    bit is_mode;
    int h;
    int m;
    int s;
    bit ed;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit i);
    if (m) btn_mode = 1'b0;
    if (i) btn_inc = 1'b0;
    step(DB + 6);
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    step(DB + 6);
  endtask

  task automatic model_mode();
    if (m_st == 0) begin
      mh = int'(hour_in);
      mm = int'(min_in);
      ms = int'(sec_in);
      m_st = 1;
    end else if (m_st == 3) begin
      m_st = 0;
      exp_loads++;
    end else begin
      m_st++;
    end
  endtask

  task automatic model_inc();
    case (m_st)
      1: mh = (mh > 23) ? 0 : (mh + 1) % 24;
      2: mm = (mm > 59) ? 0 : (mm + 1) % 60;
      3: ms = (ms > 59) ? 0 : (ms + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_st = 0;
    mh = 0;
    mm = 0;
    ms = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_hour"}, int'(set_hour), mh);
    chk({tag, "_min"}, int'(set_min), mm);
    chk({tag, "_sec"}, int'(set_sec), ms);
    chk({tag, "_editing"}, int'(editing), (m_st != 0) ? 1 : 0);
    chk({tag, "_loads"}, load_cnt, exp_loads);
  endtask

  task automatic mode_step(input string tag);
    press(1'b1, 1'b0);
    model_mode();
    check_model(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int trans;
    int prev_b;
    int exp_b;
    int loads_before;

    tbl[0] = '{1'b1, 23, 59, 58, 1'b1};
    tbl[1] = '{1'b0,  0, 59, 58, 1'b1};
    tbl[2] = '{1'b1,  0, 59, 58, 1'b1};
    tbl[3] = '{1'b0,  0,  0, 58, 1'b1};
    tbl[4] = '{1'b0,  0,  1, 58, 1'b1};
    tbl[5] = '{1'b1,  0,  1, 58, 1'b1};
    tbl[6] = '{1'b0,  0,  1, 59, 1'b1};
    tbl[7] = '{1'b0,  0,  1,  0, 1'b1};
    tbl[8] = '{1'b0,  0,  1,  1, 1'b1};
    tbl[9] = '{1'b1,  0,  1,  1, 1'b0};

    // Reset with both buttons held down.
    @(posedge clk);
    #1;
    rst_neg = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    step(3);
    chk("rst_hour", int'(set_hour), 0);
    chk("rst_min", int'(set_min), 0);
    chk("rst_sec", int'(set_sec), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_editing", int'(editing), 0);
    chk("rst_blank", int'(blank), 0);
    rst_neg = 1'b1;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    model_reset();
    step(20);
    chk("rst_no_event_editing", int'(editing), 0);
    chk("rst_no_event_loads", load_cnt, 0);

    // Press latency: state changes DB+4 edges after the raw edge.
    hour_in = 5'd5;
    min_in = 6'd6;
    sec_in = 6'd7;
    btn_mode = 1'b0;
    step(DB + 3);
    chk("lat_before", int'(editing), 0);
    step(1);
    chk("lat_at", int'(editing), 1);
    step(DB + 2);
    btn_mode = 1'b1;
    step(DB + 6);
    model_mode();
    check_model("lat_capture");
    mode_step("lat_m1");
    mode_step("lat_m2");
    mode_step("lat_m3");

    // Full edit, table driven.
    hour_in = 5'd23;
    min_in = 6'd59;
    sec_in = 6'd58;
    loads_before = load_cnt;
    for (int k = 0; k < 10; k++) begin
      press(tbl[k].is_mode, !tbl[k].is_mode);
      if (tbl[k].is_mode) model_mode();
      else model_inc();
      chk($sformatf("edit%0d_hour", k), int'(set_hour), tbl[k].h);
      chk($sformatf("edit%0d_min", k), int'(set_min), tbl[k].m);
      chk($sformatf("edit%0d_sec", k), int'(set_sec), tbl[k].s);
      chk($sformatf("edit%0d_editing", k), int'(editing), int'(tbl[k].ed));
    end
    chk("edit_load_count", load_cnt, loads_before + 1);
    chk("edit_load_hour", ld_h, 0);
    chk("edit_load_min", ld_m, 1);
    chk("edit_load_sec", ld_s, 1);

    // Bounce on inc in SET_MIN.
    hour_in = 5'd10;
    min_in = 6'd20;
    sec_in = 6'd30;
    mode_step("bnc_h");
    mode_step("bnc_m");
    for (int k = 0; k < 10; k++) begin
      btn_inc = (k % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
    end
    step(DB + 4);
    chk("bnc_quiet_min", int'(set_min), mm);
    press(1'b0, 1'b1);
    model_inc();
    check_model("bnc_one");

    // Blink in SET_MIN.
    trans = 0;
    prev_b = int'(blank);
    for (int k = 0; k < 33; k++) begin
      step(1);
      exp_b = ((cyc >> BB) & 1) ? 12 : 0;
      chk($sformatf("blink_min%0d", k), int'(blank), exp_b);
      if (int'(blank) != prev_b) trans++;
      prev_b = int'(blank);
    end
    chk("blink_min_transitions", trans, 4);

    // Simultaneous mode+inc in SET_HOUR.
    mode_step("sim_s");
    mode_step("sim_run");
    mode_step("sim_h");
    press(1'b1, 1'b1);
    model_mode();
    check_model("sim_both");
    press(1'b0, 1'b1);
    model_inc();
    check_model("sim_after_inc");

    // Blink in RUN.
    mode_step("run_s");
    mode_step("run_run");
    for (int k = 0; k < 33; k++) begin
      step(1);
      chk($sformatf("blink_run%0d", k), int'(blank), 0);
    end

    // Randomised presses against the model.
    for (int k = 0; k < 40; k++) begin
      int act;
      hour_in = 5'($urandom_range(0, 31));
      min_in = 6'($urandom_range(0, 63));
      sec_in = 6'($urandom_range(0, 63));
      act = int'($urandom_range(0, 2));
      if (act == 0) begin
        press(1'b1, 1'b0);
        model_mode();
      end else if (act == 1) begin
        press(1'b0, 1'b1);
        model_inc();
      end else begin
        press(1'b1, 1'b1);
        model_mode();
      end
      check_model($sformatf("rnd%0d", k));
    end

    // Reset in the middle of an edit.
    for (int k = 0; k < 4; k++) begin
      if (m_st != 3) mode_step($sformatf("pre_rst%0d", k));
    end
    chk("pre_rst_in_sec", m_st, 3);
    rst_neg = 1'b0;
    step(2);
    rst_neg = 1'b1;
    model_reset();
    step(DB + 6);
    check_model("midrst");
    chk("midrst_blank", int'(blank), 0);

    chk("load_not_back_to_back", int'(load_consec), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
